// File: rtl/lcd_text_ctrl.sv
// HD44780-style ROWS x COLS text panel driver: runs init, then redraws the buffer on request or change.
// One bus transaction per STEP_CYCLES (CLEAR_CYCLES for clear); writes are never stalled, busy flags activity.
module lcd_text_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int STEP_CYCLES  = 25000,
  parameter int CLEAR_CYCLES = 100000,
  localparam int N  = ROWS * COLS,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          refresh,
  output logic          busy,
  output logic          frame_done,
  output logic [10:0]   n_LCD_DATA
);

  localparam int             CW       = $clog2(CLEAR_CYCLES + 1);
  localparam logic [AW:0]    N_L      = (AW + 1)'(N);
  localparam logic [5:0]     LAST_COL = 6'(COLS - 1);
  localparam logic [1:0]     LAST_ROW = 2'(ROWS - 1);

  typedef enum logic [1:0] {INIT, IDLE, SET_ADDR, WRITE_CHAR} state_t;

  state_t        state, n_state;
  logic [7:0]    text_buf [N];
  logic [1:0]    init_idx, n_init, row, n_row;
  logic [5:0]    col, n_col;
  logic [CW-1:0] cnt, len;
  logic          pending, dirty, accept, step_end;
  logic          launch, l_rs, l_clear, take, fin;
  logic [7:0]    l_db;
  logic [AW-1:0] rd_addr;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0E;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h80;
      2'd1:    return 8'hC0;
      2'd2:    return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  assign accept   = wr_en && ({1'b0, wr_addr} < N_L);
  assign step_end = busy && (cnt == len - 1'b1);

  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) text_buf[i] <= 8'h20;
    end else if (accept) begin
      text_buf[wr_addr] <= wr_data;
    end
  end

  // Decide which transaction (if any) occupies the bus from the next edge on.
  always_comb begin
    n_state = state;
    n_init  = init_idx;
    n_row   = row;
    n_col   = col;
    launch  = 1'b0;
    l_rs    = 1'b0;
    l_db    = 8'h00;
    take    = 1'b0;
    fin     = 1'b0;
    rd_addr = '0;
    case (state)
      INIT: begin
        if (!busy) begin
          launch = 1'b1;
          l_db   = init_cmd(init_idx);
        end else if (step_end) begin
          launch = 1'b1;
          if (init_idx == 2'd3) begin
            n_state = SET_ADDR;
            n_row   = 2'd0;
            n_col   = 6'd0;
            l_db    = row_cmd(2'd0);
          end else begin
            n_init = init_idx + 2'd1;
            l_db   = init_cmd(n_init);
          end
        end
      end
      IDLE: begin
        if (pending || dirty) begin
          take    = 1'b1;
          n_state = SET_ADDR;
          n_row   = 2'd0;
          n_col   = 6'd0;
          launch  = 1'b1;
          l_db    = row_cmd(2'd0);
        end
      end
      SET_ADDR: begin
        if (step_end) begin
          n_state = WRITE_CHAR;
          rd_addr = AW'(int'(row) * COLS + int'(col));
          launch  = 1'b1;
          l_rs    = 1'b1;
          l_db    = text_buf[rd_addr];
        end
      end
      WRITE_CHAR: begin
        if (step_end) begin
          if (col == LAST_COL) begin
            n_col = 6'd0;
            if (row == LAST_ROW) begin
              n_state = IDLE;
              fin     = 1'b1;
            end else begin
              n_row   = row + 2'd1;
              n_state = SET_ADDR;
              launch  = 1'b1;
              l_db    = row_cmd(n_row);
            end
          end else begin
            n_col   = col + 6'd1;
            rd_addr = AW'(int'(row) * COLS + int'(col) + 1);
            launch  = 1'b1;
            l_rs    = 1'b1;
            l_db    = text_buf[rd_addr];
          end
        end
      end
      default: n_state = INIT;
    endcase
    l_clear = (state == INIT) && (l_db == 8'h01);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= INIT;
      init_idx   <= 2'd0;
      row        <= 2'd0;
      col        <= 6'd0;
      cnt        <= '0;
      len        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      n_LCD_DATA <= 11'd0;
      pending    <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      state      <= n_state;
      init_idx   <= n_init;
      row        <= n_row;
      col        <= n_col;
      frame_done <= fin;
      // A request landing on the same edge as the take must survive it.
      pending    <= (pending && !take) || refresh;
      dirty      <= (dirty && !take) || accept;
      if (launch) begin
        busy       <= 1'b1;
        cnt        <= '0;
        len        <= l_clear ? CW'(CLEAR_CYCLES) : CW'(STEP_CYCLES);
        n_LCD_DATA <= {1'b1, l_rs, 1'b0, l_db};
      end else if (step_end) begin
        busy       <= 1'b0;
        n_LCD_DATA <= 11'd0;
      end else if (busy) begin
        cnt            <= cnt + 1'b1;
        n_LCD_DATA[10] <= (cnt + 1'b1) < (len >> 1);
      end
    end
  end

endmodule
